// File: rtl/mac_pkg.sv
// Shared types and constants for the mac_more issuing sequencer.
package mac_pkg;

   localparam int DATA_W = 16;
   localparam int ACC_W  = 32;

   typedef enum logic [0:0] {
      IDLE,
      RUN
   } mac_seq_state_t;

   // Bits needed to hold the values 0..max_val, never less than one.
   function automatic int cnt_w(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/mac_seq_dly.sv
// N-stage single-bit delay line, cleared by reset. Produces the fifo enqueue
// and buffer write strobes from the read windows.
module mac_seq_dly #(
   parameter int N = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   logic [N-1:0] sr_q;
   logic [N-1:0] sr_d;

   // Shift one stage per cycle, new sample enters at bit 0.
   always_comb begin
      sr_d    = sr_q;
      sr_d[0] = din;
      for (int i = 1; i < N; i++) begin
         sr_d[i] = sr_q[i-1];
      end
   end

   // Stage registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign dout = sr_q[N-1];

endmodule

// File: rtl/mac_seq.sv
// Issuing side of the mac_more array: runs one tile from start to done.
// Reads weight / ifmap / accum_in rows from single-cycle-latency buffers,
// drives the skewed enqueue strobes and writes accum_out rows back.
// Optional build macro: MAC_SEQ_ZERO_ACCUM_EN adds the zero_accum input, which
// replaces the accum_in rows with zero for the whole tile.
//
//   state | meaning
//   IDLE  | waiting for start; config registers hold the previous tile
//   RUN   | tile in flight; tmr counts down to the cycle of the last write
//
// Cycle c = 0 is the first RUN cycle. Weight reads occupy c = 0..IC0-1, pixel
// reads c = 1..N, and the last write lands at c = 2+PIPE_LAT+N when tmr hits 0.
module mac_seq
   import mac_pkg::*;
#(
   parameter int IC0      = 2,
   parameter int OC0      = 2,
   parameter int PIPE_LAT = 2,
   parameter int MAX_PIX  = 64,
   parameter int AW       = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [$clog2(MAX_PIX+1)-1:0]  npix,
   input  logic [AW-1:0]                 w_base,
   input  logic [AW-1:0]                 if_base,
   input  logic [AW-1:0]                 ai_base,
   input  logic [AW-1:0]                 ao_base,
`ifdef MAC_SEQ_ZERO_ACCUM_EN
   input  logic                          zero_accum,
`endif
   output logic                          busy,
   output logic                          done,
   output logic                          weight_rd_en,
   output logic [AW-1:0]                 weight_rd_addr,
   input  logic [DATA_W*OC0-1:0]         weight_rd_data,
   output logic                          ifmap_rd_en,
   output logic [AW-1:0]                 ifmap_rd_addr,
   input  logic [DATA_W*IC0-1:0]         ifmap_rd_data,
   output logic                          accum_rd_en,
   output logic [AW-1:0]                 accum_rd_addr,
   input  logic [ACC_W*OC0-1:0]          accum_rd_data,
   output logic                          en,
   output logic                          en_weight00,
   output logic                          weight_fifo_enq,
   output logic                          ifmap_fifo_enq,
   output logic                          accum_in_fifo_enq,
   output logic                          accum_out_fifo_enq,
   output logic [DATA_W*OC0-1:0]         weight_dat_chained_fifo_in,
   output logic [DATA_W*IC0-1:0]         ifmap_dat_chained_fifo_in,
   output logic [ACC_W*OC0-1:0]          accum_in_chained_fifo_in,
   input  logic [ACC_W*OC0-1:0]          accum_out_chained_fifo_out,
   output logic                          accum_wr_en,
   output logic [AW-1:0]                 accum_wr_addr,
   output logic [ACC_W*OC0-1:0]          accum_wr_data
);

   localparam int PIX_W = $clog2(MAX_PIX + 1);
   localparam int WC_W  = cnt_w(IC0);
   localparam int TMR_W = cnt_w(2 + PIPE_LAT + MAX_PIX);

   mac_seq_state_t       state_q, state_d;
   logic [PIX_W-1:0]     npix_q, npix_d;
   logic [AW-1:0]        w_base_q, w_base_d;
   logic [AW-1:0]        if_base_q, if_base_d;
   logic [AW-1:0]        ai_base_q, ai_base_d;
   logic [AW-1:0]        ao_base_q, ao_base_d;
   logic                 first_q, first_d;
   logic [WC_W-1:0]      w_cnt_q, w_cnt_d;
   logic [PIX_W-1:0]     px_cnt_q, px_cnt_d;
   logic [AW-1:0]        wr_cnt_q, wr_cnt_d;
   logic [TMR_W-1:0]     tmr_q, tmr_d;
   logic                 done_q, done_d;
   logic [ACC_W*OC0-1:0] wr_data_q, wr_data_d;
   logic                 zero_q, zero_d;
   logic                 zero_in;

   logic run;
   logic pix_rd;
   logic w_first_rd;
   logic pix_enq;

`ifdef MAC_SEQ_ZERO_ACCUM_EN
   assign zero_in = zero_accum;
`else
   assign zero_in = 1'b0;
`endif

   assign run        = (state_q == RUN);
   assign pix_rd     = run && !first_q && (px_cnt_q < npix_q);
   assign w_first_rd = weight_rd_en && (w_cnt_q == '0);

   assign busy           = run;
   assign done           = done_q;
   assign en             = run && !first_q;
   assign weight_rd_en   = run && (w_cnt_q < WC_W'(IC0));
   assign weight_rd_addr = w_base_q + AW'(w_cnt_q);
   assign ifmap_rd_en    = pix_rd;
   assign ifmap_rd_addr  = if_base_q + AW'(px_cnt_q);
   assign accum_rd_en    = pix_rd && !zero_q;
   assign accum_rd_addr  = ai_base_q + AW'(px_cnt_q);
   assign accum_wr_addr  = ao_base_q + wr_cnt_q;
   assign accum_wr_data  = wr_data_q;

   mac_seq_dly #(.N(1)) u_w_enq (
      .clk (clk), .rst (rst), .din (weight_rd_en), .dout (weight_fifo_enq)
   );

   mac_seq_dly #(.N(1)) u_w00 (
      .clk (clk), .rst (rst), .din (w_first_rd), .dout (en_weight00)
   );

   // ifmap and accum_in share one window; the accum enqueue keeps its timing
   // even when the accum read itself is suppressed.
   mac_seq_dly #(.N(1)) u_px_enq (
      .clk (clk), .rst (rst), .din (pix_rd), .dout (pix_enq)
   );

   mac_seq_dly #(.N(1 + PIPE_LAT)) u_ao_enq (
      .clk (clk), .rst (rst), .din (pix_rd), .dout (accum_out_fifo_enq)
   );

   mac_seq_dly #(.N(1)) u_wr (
      .clk (clk), .rst (rst), .din (accum_out_fifo_enq), .dout (accum_wr_en)
   );

   assign ifmap_fifo_enq    = pix_enq;
   assign accum_in_fifo_enq = pix_enq;

   // Read data flows straight through to the array, gated to zero between strobes.
   assign weight_dat_chained_fifo_in = weight_fifo_enq ? weight_rd_data : '0;
   assign ifmap_dat_chained_fifo_in  = ifmap_fifo_enq ? ifmap_rd_data : '0;
   assign accum_in_chained_fifo_in   = (accum_in_fifo_enq && !zero_q) ? accum_rd_data : '0;

   // Next-state, config capture and per-phase counters.
   always_comb begin
      state_d   = state_q;
      npix_d    = npix_q;
      w_base_d  = w_base_q;
      if_base_d = if_base_q;
      ai_base_d = ai_base_q;
      ao_base_d = ao_base_q;
      zero_d    = zero_q;
      first_d   = first_q;
      w_cnt_d   = w_cnt_q;
      px_cnt_d  = px_cnt_q;
      wr_cnt_d  = wr_cnt_q;
      tmr_d     = tmr_q;
      done_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (npix == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d   = RUN;
                  npix_d    = npix;
                  w_base_d  = w_base;
                  if_base_d = if_base;
                  ai_base_d = ai_base;
                  ao_base_d = ao_base;
                  zero_d    = zero_in;
                  first_d   = 1'b1;
                  w_cnt_d   = '0;
                  px_cnt_d  = '0;
                  wr_cnt_d  = '0;
                  tmr_d     = TMR_W'(2 + PIPE_LAT) + TMR_W'(npix);
               end
            end
         end
         RUN: begin
            first_d = 1'b0;
            if (weight_rd_en) begin
               w_cnt_d = w_cnt_q + 1'b1;
            end
            if (pix_rd) begin
               px_cnt_d = px_cnt_q + 1'b1;
            end
            if (accum_wr_en) begin
               wr_cnt_d = wr_cnt_q + 1'b1;
            end
            if (tmr_q == '0) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Capture the array output on its enqueue; it is written one cycle later.
   always_comb begin
      wr_data_d = wr_data_q;
      if (accum_out_fifo_enq) begin
         wr_data_d = accum_out_chained_fifo_out;
      end
   end

   // State, config and counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         npix_q    <= '0;
         w_base_q  <= '0;
         if_base_q <= '0;
         ai_base_q <= '0;
         ao_base_q <= '0;
         zero_q    <= 1'b0;
         first_q   <= 1'b0;
         w_cnt_q   <= '0;
         px_cnt_q  <= '0;
         wr_cnt_q  <= '0;
         tmr_q     <= '0;
         done_q    <= 1'b0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         npix_q    <= npix_d;
         w_base_q  <= w_base_d;
         if_base_q <= if_base_d;
         ai_base_q <= ai_base_d;
         ao_base_q <= ao_base_d;
         zero_q    <= zero_d;
         first_q   <= first_d;
         w_cnt_q   <= w_cnt_d;
         px_cnt_q  <= px_cnt_d;
         wr_cnt_q  <= wr_cnt_d;
         tmr_q     <= tmr_d;
         done_q    <= done_d;
         wr_data_q <= wr_data_d;
      end
   end

endmodule

// File: tb/tb_mac_seq.sv
// Bench for mac_seq: buffer models, a behavioural 2x2 mac_more model and
// per-cycle strobe timeline checks. Also exercises MAC_SEQ_ZERO_ACCUM_EN when defined.
module tb_mac_seq;

   localparam int IC0 = 2;
   localparam int PL  = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [6:0]  npix;
   logic [7:0]  w_base, if_base, ai_base, ao_base;
`ifdef MAC_SEQ_ZERO_ACCUM_EN
   logic        zero_accum;
`endif
   logic        busy, done;
   logic        weight_rd_en, ifmap_rd_en, accum_rd_en;
   logic [7:0]  weight_rd_addr, ifmap_rd_addr, accum_rd_addr;
   logic [31:0] weight_rd_data = '0;
   logic [31:0] ifmap_rd_data = '0;
   logic [63:0] accum_rd_data = '0;
   logic        en, en_weight00;
   logic        weight_fifo_enq, ifmap_fifo_enq, accum_in_fifo_enq, accum_out_fifo_enq;
   logic [31:0] weight_dat_chained_fifo_in;
   logic [31:0] ifmap_dat_chained_fifo_in;
   logic [63:0] accum_in_chained_fifo_in;
   logic [63:0] accum_out_chained_fifo_out = '0;
   logic        accum_wr_en;
   logic [7:0]  accum_wr_addr;
   logic [63:0] accum_wr_data;

   int n_assert = 0;
   int n_fail   = 0;

   logic [31:0] wmem [256];
   logic [31:0] imem [256];
   logic [63:0] amem [256];

   logic [63:0] rq [$];
   logic [71:0] wr_q [$];
   logic [31:0] wrow [2];
   int          widx = 0;
   int          done_cnt = 0;

   mac_seq dut (
      .clk                        (clk),
      .rst                        (rst),
      .start                      (start),
      .npix                       (npix),
      .w_base                     (w_base),
      .if_base                    (if_base),
      .ai_base                    (ai_base),
      .ao_base                    (ao_base),
`ifdef MAC_SEQ_ZERO_ACCUM_EN
      .zero_accum                 (zero_accum),
`endif
      .busy                       (busy),
      .done                       (done),
      .weight_rd_en               (weight_rd_en),
      .weight_rd_addr             (weight_rd_addr),
      .weight_rd_data             (weight_rd_data),
      .ifmap_rd_en                (ifmap_rd_en),
      .ifmap_rd_addr              (ifmap_rd_addr),
      .ifmap_rd_data              (ifmap_rd_data),
      .accum_rd_en                (accum_rd_en),
      .accum_rd_addr              (accum_rd_addr),
      .accum_rd_data              (accum_rd_data),
      .en                         (en),
      .en_weight00                (en_weight00),
      .weight_fifo_enq            (weight_fifo_enq),
      .ifmap_fifo_enq             (ifmap_fifo_enq),
      .accum_in_fifo_enq          (accum_in_fifo_enq),
      .accum_out_fifo_enq         (accum_out_fifo_enq),
      .weight_dat_chained_fifo_in (weight_dat_chained_fifo_in),
      .ifmap_dat_chained_fifo_in  (ifmap_dat_chained_fifo_in),
      .accum_in_chained_fifo_in   (accum_in_chained_fifo_in),
      .accum_out_chained_fifo_out (accum_out_chained_fifo_out),
      .accum_wr_en                (accum_wr_en),
      .accum_wr_addr              (accum_wr_addr),
      .accum_wr_data              (accum_wr_data)
   );

   always #5 clk = ~clk;

   // 2x2 array result: out[j] = acc[j] + sum_i w_row_i[j] * x[i], 32-bit wrap.
   function automatic logic [63:0] mac_fn(input logic [31:0] w0, input logic [31:0] w1,
                                          input logic [31:0] x, input logic [63:0] a);
      logic [31:0] w [2];
      logic signed [31:0] s;
      logic [63:0] r;
      w[0] = w0;
      w[1] = w1;
      r = '0;
      for (int j = 0; j < 2; j++) begin
         s = a[32*j +: 32];
         for (int i = 0; i < 2; i++) begin
            s = s + $signed(w[i][16*j +: 16]) * $signed(x[16*i +: 16]);
         end
         r[32*j +: 32] = s;
      end
      return r;
   endfunction

   // Expected k-th output row straight from buffer contents.
   function automatic logic [63:0] ref_pix(input logic [7:0] wb, input logic [7:0] ib,
                                           input logic [7:0] ab, input int k, input bit z);
      logic [7:0] w1a, ia, aa;
      w1a = wb + 8'd1;
      ia  = ib + 8'(k);
      aa  = ab + 8'(k);
      return mac_fn(wmem[wb], wmem[w1a], imem[ia], z ? 64'd0 : amem[aa]);
   endfunction

   // Single-cycle-latency buffers.
   always @(posedge clk) begin
      if (weight_rd_en) weight_rd_data <= wmem[weight_rd_addr];
      if (ifmap_rd_en)  ifmap_rd_data  <= imem[ifmap_rd_addr];
      if (accum_rd_en)  accum_rd_data  <= amem[accum_rd_addr];
   end

   // mac_more model plus write/done monitor.
   always @(negedge clk) begin
      if (rst) begin
         rq.delete();
         widx = 0;
      end else begin
         if (weight_fifo_enq) begin
            if (en_weight00) widx = 0;
            if (widx < 2) wrow[widx] = weight_dat_chained_fifo_in;
            widx++;
         end
         if (ifmap_fifo_enq)
            rq.push_back(mac_fn(wrow[0], wrow[1], ifmap_dat_chained_fifo_in,
                                accum_in_fifo_enq ? accum_in_chained_fifo_in : 64'd0));
         if (accum_out_fifo_enq) begin
            if (rq.size() > 0) accum_out_chained_fifo_out = rq.pop_front();
            else accum_out_chained_fifo_out = '0;
         end
         if (accum_wr_en) wr_q.push_back({accum_wr_addr, accum_wr_data});
         if (done) done_cnt++;
      end
   end

   task automatic load_scn1(input logic [7:0] wb, input logic [7:0] ib, input logic [7:0] ab);
      logic [7:0] a;
      wmem[wb] = {16'd2, 16'd1};
      a = wb + 8'd1;
      wmem[a] = {16'd4, 16'd3};
      for (int k = 0; k < 4; k++) begin
         a = ib + 8'(k);
         imem[a] = {16'(9 + k), 16'(5 + k)};
         a = ab + 8'(k);
         amem[a] = {32'(k + 1), 32'(-(k + 1))};
      end
   endtask

   task automatic run_tile(input int n, input logic [7:0] wb, input logic [7:0] ib,
                           input logic [7:0] ab, input logic [7:0] ob,
                           input int restart_c, input bit z, input string tag);
      logic [11:0] got, exp;
      logic [63:0] ed;
      w_base  = wb;
      if_base = ib;
      ai_base = ab;
      ao_base = ob;
      npix    = 7'(n);
`ifdef MAC_SEQ_ZERO_ACCUM_EN
      zero_accum = z;
`endif
      wr_q.delete();
      rq.delete();
      done_cnt = 0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c <= n + 7; c++) begin
         exp = {(n > 0) && (c <= 2 + PL + n),
                (n > 0) ? (c == n + 3 + PL) : (c == 0),
                (n > 0) && (c >= 1) && (c <= 2 + PL + n),
                (n > 0) && (c == 1),
                (n > 0) && (c <= IC0 - 1),
                (c >= 1) && (c <= n),
                (c >= 1) && (c <= n) && !z,
                (n > 0) && (c >= 1) && (c <= IC0),
                (c >= 2) && (c <= n + 1),
                (c >= 2) && (c <= n + 1),
                (c >= 2 + PL) && (c <= 1 + PL + n),
                (c >= 3 + PL) && (c <= 2 + PL + n)};
         got = {busy, done, en, en_weight00, weight_rd_en, ifmap_rd_en, accum_rd_en,
                weight_fifo_enq, ifmap_fifo_enq, accum_in_fifo_enq, accum_out_fifo_enq,
                accum_wr_en};
         n_assert++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL %s strobes c=%0d got=%b exp=%b", tag, c, got, exp);
         end
         if (exp[7]) begin
            n_assert++;
            if (weight_rd_addr !== 8'(wb + 8'(c))) begin
               n_fail++;
               $display("FAIL %s w_addr c=%0d got=%h exp=%h", tag, c, weight_rd_addr, 8'(wb + 8'(c)));
            end
         end
         if (exp[6]) begin
            n_assert++;
            if (ifmap_rd_addr !== 8'(ib + 8'(c - 1)) ||
                (!z && accum_rd_addr !== 8'(ab + 8'(c - 1)))) begin
               n_fail++;
               $display("FAIL %s px_addr c=%0d got=%h/%h exp=%h/%h", tag, c, ifmap_rd_addr,
                        accum_rd_addr, 8'(ib + 8'(c - 1)), 8'(ab + 8'(c - 1)));
            end
         end
         start = (c == restart_c);
         @(negedge clk);
      end
      start = 1'b0;
      n_assert++;
      if (wr_q.size() != n || done_cnt != 1) begin
         n_fail++;
         $display("FAIL %s counts got writes=%0d done=%0d exp writes=%0d done=1", tag,
                  wr_q.size(), done_cnt, n);
      end
      for (int k = 0; k < n && k < wr_q.size(); k++) begin
         ed = ref_pix(wb, ib, ab, k, z);
         n_assert++;
         if (wr_q[k] !== {8'(ob + 8'(k)), ed}) begin
            n_fail++;
            $display("FAIL %s write k=%0d got=%h exp=%h", tag, k, wr_q[k], {8'(ob + 8'(k)), ed});
         end
      end
   endtask

   task automatic check_scn1_consts(input bit z, input string tag);
      logic [63:0] exp [4];
      for (int k = 0; k < 4; k++) begin
         if (z) exp[k] = {32'(46 + 6 * k), 32'(32 + 4 * k)};
         else   exp[k] = {32'(47 + 7 * k), 32'(31 + 3 * k)};
         n_assert++;
         if (k >= wr_q.size() || wr_q[k][63:0] !== exp[k]) begin
            n_fail++;
            $display("FAIL %s const k=%0d got=%h exp=%h", tag, k,
                     (k < wr_q.size()) ? wr_q[k][63:0] : 64'hx, exp[k]);
         end
      end
   endtask

   task automatic test_reset;
      logic [127:0] v;
      rst = 1'b1;
      start = 1'b0;
      npix = '0;
      w_base = '0; if_base = '0; ai_base = '0; ao_base = '0;
`ifdef MAC_SEQ_ZERO_ACCUM_EN
      zero_accum = 1'b0;
`endif
      repeat (3) @(negedge clk);
      v = 128'({busy, done, weight_rd_en, ifmap_rd_en, accum_rd_en, en, en_weight00,
                weight_fifo_enq, ifmap_fifo_enq, accum_in_fifo_enq, accum_out_fifo_enq,
                accum_wr_en, weight_rd_addr, ifmap_rd_addr, accum_rd_addr, accum_wr_addr});
      n_assert++;
      if (v !== '0 || accum_wr_data !== '0) begin
         n_fail++;
         $display("FAIL reset outputs got=%h/%h exp=0", v, accum_wr_data);
      end
      rst = 1'b0;
   endtask

   task automatic test_tile;
      load_scn1(8'h10, 8'h20, 8'h30);
      run_tile(4, 8'h10, 8'h20, 8'h30, 8'h40, -1, 1'b0, "scn1");
      check_scn1_consts(1'b0, "scn1");
   endtask

   task automatic test_restart_ignored;
      load_scn1(8'h50, 8'h60, 8'h70);
      run_tile(4, 8'h50, 8'h60, 8'h70, 8'h80, 3, 1'b0, "restart");
   endtask

   task automatic test_zero_pix;
      run_tile(0, 8'h00, 8'h00, 8'h00, 8'h00, -1, 1'b0, "npix0");
   endtask

   task automatic test_reset_mid;
      logic [127:0] v;
      load_scn1(8'hF0, 8'hFE, 8'h08);
      w_base = 8'hF0; if_base = 8'hFE; ai_base = 8'h08; ao_base = 8'hFD;
      npix = 7'd4;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      v = 128'({busy, done, weight_rd_en, ifmap_rd_en, accum_rd_en, en, en_weight00,
                weight_fifo_enq, ifmap_fifo_enq, accum_in_fifo_enq, accum_out_fifo_enq,
                accum_wr_en, weight_rd_addr, ifmap_rd_addr, accum_rd_addr, accum_wr_addr});
      n_assert++;
      if (v !== '0 || accum_wr_data !== '0 || weight_dat_chained_fifo_in !== '0 ||
          ifmap_dat_chained_fifo_in !== '0 || accum_in_chained_fifo_in !== '0) begin
         n_fail++;
         $display("FAIL midrst outputs got=%h exp=0", v);
      end
      rst = 1'b0;
      done_cnt = 0;
      wr_q.delete();
      repeat (10) @(negedge clk);
      n_assert++;
      if (done_cnt != 0 || wr_q.size() != 0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst quiet got done=%0d writes=%0d busy=%b exp 0/0/0",
                  done_cnt, wr_q.size(), busy);
      end
      run_tile(4, 8'hF0, 8'hFE, 8'h08, 8'hFD, -1, 1'b0, "rerun");
      check_scn1_consts(1'b0, "rerun");
   endtask

   task automatic test_random;
      int n;
      logic [7:0] wb, ib, ab, ob;
      for (int t = 0; t < 6; t++) begin
         for (int i = 0; i < 256; i++) begin
            wmem[i] = $urandom;
            imem[i] = $urandom;
            amem[i] = {$urandom, $urandom};
         end
         n  = $urandom_range(1, 24);
         wb = 8'($urandom);
         ib = 8'($urandom);
         ab = 8'($urandom);
         ob = 8'($urandom);
         run_tile(n, wb, ib, ab, ob, -1, 1'b0, "random");
      end
   endtask

`ifdef MAC_SEQ_ZERO_ACCUM_EN
   task automatic test_zero_accum;
      load_scn1(8'h10, 8'h20, 8'h30);
      run_tile(4, 8'h10, 8'h20, 8'h30, 8'h40, -1, 1'b1, "zacc");
      check_scn1_consts(1'b1, "zacc");
   endtask
`endif

   initial begin
      test_reset;
      test_tile;
      test_restart_ignored;
      test_zero_pix;
      test_reset_mid;
      test_random;
`ifdef MAC_SEQ_ZERO_ACCUM_EN
      test_zero_accum;
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
